uart_tx_arbiter: RTL and testbench

- Shares one uart_tx byte channel (tx_data / tx_data_valid / tx_data_ready) between NUM_REQ independent requesters.
- Each requester streams bytes with a last flag marking the end of a message. The grant is held for the whole message, so messages never interleave on the serial line.
- Round-robin arbitration, a per-grant burst limit and an idle timeout prevent starvation.
- Sits between client logic (echo path, status reporter, debug dumper) and the uart_tx instance.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the uart_tx arbiter, its byte-stream clients and uart_tx.
// The slave modport is the arbiter's view; master is the surrounding logic
// that drives the requester streams and the uart_tx ready.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_data_valid;
  logic                          tx_data_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_data_ready,
    output req_ready, tx_data, tx_data_valid, grant, busy
  );

  modport master (
    output req_valid, req_data, req_last, tx_data_ready,
    input  req_ready, tx_data, tx_data_valid, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one uart_tx byte channel.
// A grant is held until the message ends, the burst limit is hit, or the
// owner stays silent for IDLE_TIMEOUT cycles.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; pick next valid requester after last_idx
// ST_GRANT | gidx owns the channel; its bytes pass straight to uart_tx
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 2700
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  // Compare against limit-1 so the counters never need to reach the limit.
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST  = (IDLE_TIMEOUT > 0) ? IW'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] RST_LAST   = GW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [GW-1:0]      gidx_q, gidx_d;
  logic [GW-1:0]      last_idx_q, last_idx_d;

  logic [GW-1:0]         sel;
  logic                  found;
  logic [DATA_WIDTH-1:0] tx_data_c;
  logic                  tx_valid_c;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic                  g_valid;
  logic                  g_last;
  logic                  xfer;
  logic                  rel;

  // Wrap modulo NUM_REQ explicitly so non-power-of-2 counts rotate correctly.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    return GW'((int'(base) + off) % NUM_REQ);
  endfunction

  // Round-robin pick: first valid requester strictly after the previous owner.
  always_comb begin
    sel   = last_idx_q;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!found && bus.req_valid[rr_idx(last_idx_q, off)]) begin
        found = 1'b1;
        sel   = rr_idx(last_idx_q, off);
      end
    end
  end

  // Pass-through datapath from the owner to uart_tx; everything quiet when idle.
  always_comb begin
    tx_data_c   = '0;
    tx_valid_c  = 1'b0;
    req_ready_c = '0;
    g_valid     = 1'b0;
    g_last      = 1'b0;
    if (state_q == ST_GRANT) begin
      g_valid             = bus.req_valid[gidx_q];
      g_last              = bus.req_last[gidx_q];
      tx_data_c           = bus.req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
      tx_valid_c          = g_valid;
      req_ready_c[gidx_q] = bus.tx_data_ready;
    end
  end

  assign xfer = tx_valid_c && bus.tx_data_ready;

  // Any of end-of-message, burst limit or owner silence ends the grant.
  assign rel = (xfer && g_last) ||
               (xfer && (beat_q == BURST_LAST)) ||
               ((IDLE_TIMEOUT > 0) && !g_valid && (idle_q == IDLE_LAST));

  // Next-state logic for the grant FSM and its counters.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    beat_d     = beat_q;
    idle_d     = idle_q;
    gidx_d     = gidx_q;
    last_idx_d = last_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          grant_d = ONE << sel;
          gidx_d  = sel;
          busy_d  = 1'b1;
          beat_d  = '0;
          idle_d  = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          beat_d = beat_q + 1'b1;
          idle_d = '0;
        end else if (!g_valid) begin
          idle_d = idle_q + 1'b1;
        end else begin
          idle_d = '0;
        end
        if (rel) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          busy_d     = 1'b0;
          beat_d     = '0;
          idle_d     = '0;
          last_idx_d = gidx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset hands first priority to requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      beat_q     <= '0;
      idle_q     <= '0;
      gidx_q     <= '0;
      last_idx_q <= RST_LAST;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      beat_q     <= beat_d;
      idle_q     <= idle_d;
      gidx_q     <= gidx_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign bus.tx_data       = tx_data_c;
  assign bus.tx_data_valid = tx_valid_c;
  assign bus.req_ready     = req_ready_c;
  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, an expected
// byte/owner queue filled as stimulus is loaded, and a negedge monitor.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic clk;
  logic rst_n;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(16), .IDLE_TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source streams: {last, data} per requester, rd advanced on handshake.
  logic [8:0] src_mem [NR][32];
  int rd [NR] = '{default: 0};
  int wr [NR] = '{default: 0};
  logic [NR-1:0] hs_q = '0;

  // Expected transfers in order: {owner id, byte}.
  logic [9:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_q.push_back({2'(id), d});
  endtask

  task automatic push_src(input int id, input logic [7:0] d, input logic last, input logic expect_it);
    src_mem[id][wr[id]] = {last, d};
    wr[id] = wr[id] + 1;
    if (expect_it) push_exp(id, d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic src_pending();
    logic p = 1'b0;
    for (int i = 0; i < NR; i++) if (rd[i] < wr[i]) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy || src_pending()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Requester model: present head of each stream shortly after every edge.
  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < NR; i++) begin
      if (hs_q[i]) rd[i] = rd[i] + 1;
      bus.req_valid[i] = (rd[i] < wr[i]);
      if (rd[i] < 32) begin
        bus.req_data[i*DW +: DW] = src_mem[i][rd[i]][7:0];
        bus.req_last[i]          = src_mem[i][rd[i]][8] && (rd[i] < wr[i]);
      end else begin
        bus.req_data[i*DW +: DW] = '0;
        bus.req_last[i]          = 1'b0;
      end
    end
  end

  // Monitor: score each uart-side transfer and track requester handshakes.
  always @(negedge clk) begin
    logic [9:0] e;
    hs_q = '0;
    if (rst_n === 1'b1) begin
      hs_q = bus.req_valid & bus.req_ready;
      checks++;
      assert ($onehot0(bus.req_ready)) else begin
        errors++;
        $error("FAIL ready_onehot: observed %0h expected one-hot or zero", bus.req_ready);
      end
      if (bus.busy) begin
        checks++;
        assert (bus.req_ready === (bus.tx_data_ready ? bus.grant : '0)) else begin
          errors++;
          $error("FAIL ready_route: observed %0h expected %0h", bus.req_ready,
                 bus.tx_data_ready ? bus.grant : '0);
        end
      end
      if (bus.tx_data_valid && bus.tx_data_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_extra: observed byte %0h expected none", bus.tx_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (bus.tx_data === e[7:0]) else begin
            errors++;
            $error("FAIL sb_data: observed %0h expected %0h", bus.tx_data, e[7:0]);
          end
          checks++;
          assert (bus.grant === (4'b0001 << e[9:8])) else begin
            errors++;
            $error("FAIL sb_owner: observed %0h expected %0h", bus.grant, 4'b0001 << e[9:8]);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.tx_data_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_txv", bus.tx_data_valid, 0);
    chk("rst_txd", bus.tx_data, 0);
    chk("rst_ready", bus.req_ready, 0);

    // Single 3-byte message from requester 0.
    tick();
    push_src(0, 8'hA1, 1'b0, 1'b1);
    push_src(0, 8'hA2, 1'b0, 1'b1);
    push_src(0, 8'hA3, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_lat_grant", bus.grant, 0);
    chk("t1_lat_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("t1_grant", bus.grant, 4'b0001);
    chk("t1_busy", bus.busy, 1);
    chk("t1_b1", bus.tx_data, 8'hA1);
    @(negedge clk);
    chk("t1_b2", bus.tx_data, 8'hA2);
    @(negedge clk);
    chk("t1_b3", bus.tx_data, 8'hA3);
    @(negedge clk);
    chk("t1_rel_busy", bus.busy, 0);
    chk("t1_rel_grant", bus.grant, 0);
    drain("t1_drain", 50);

    // Simultaneous requesters 1 and 2 after reset: 1 first, one dead cycle.
    do_reset();
    push_src(1, 8'hC1, 1'b0, 1'b1);
    push_src(1, 8'hC2, 1'b1, 1'b1);
    push_src(2, 8'hD1, 1'b0, 1'b1);
    push_src(2, 8'hD2, 1'b1, 1'b1);
    wait_neg(2);
    chk("t2_grant1", bus.grant, 4'b0010);
    chk("t2_c1", bus.tx_data, 8'hC1);
    wait_neg(1);
    chk("t2_c2", bus.tx_data, 8'hC2);
    wait_neg(1);
    chk("t2_dead", bus.grant, 0);
    chk("t2_dead_txv", bus.tx_data_valid, 0);
    wait_neg(1);
    chk("t2_grant2", bus.grant, 4'b0100);
    chk("t2_d1", bus.tx_data, 8'hD1);
    drain("t2_drain", 50);

    // Burst limit: req 3 streams 20 unterminated bytes, req 0 waits its turn.
    tick();
    for (int k = 1; k <= 20; k++) push_src(3, 8'(8'h30 + k), 1'b0, 1'b0);
    push_src(0, 8'hE1, 1'b0, 1'b0);
    push_src(0, 8'hE2, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) push_exp(3, 8'(8'h30 + k));
    push_exp(0, 8'hE1);
    push_exp(0, 8'hE2);
    for (int k = 17; k <= 20; k++) push_exp(3, 8'(8'h30 + k));
    wait_neg(2);
    chk("t3_grant3", bus.grant, 4'b1000);
    wait_neg(16);
    chk("t3_forced_rel", bus.grant, 0);
    wait_neg(1);
    chk("t3_grant0", bus.grant, 4'b0001);
    drain("t3_drain", 200);

    // Idle timeout: req 0 sends one byte then goes quiet; req 1 pending.
    tick();
    push_src(0, 8'hF1, 1'b0, 1'b1);
    push_src(1, 8'h71, 1'b1, 1'b1);
    wait_neg(2);
    chk("t4_grant0", bus.grant, 4'b0001);
    chk("t4_f1", bus.tx_data, 8'hF1);
    wait_neg(8);
    chk("t4_hold", bus.grant, 4'b0001);
    chk("t4_hold_txv", bus.tx_data_valid, 0);
    wait_neg(1);
    chk("t4_timeout", bus.grant, 0);
    wait_neg(1);
    chk("t4_grant1", bus.grant, 4'b0010);
    chk("t4_g1", bus.tx_data, 8'h71);
    drain("t4_drain", 50);

    // uart_tx back-pressure mid-message.
    tick();
    push_src(2, 8'h81, 1'b0, 1'b1);
    push_src(2, 8'h82, 1'b0, 1'b1);
    push_src(2, 8'h83, 1'b1, 1'b1);
    wait_neg(2);
    chk("t5_grant2", bus.grant, 4'b0100);
    chk("t5_h1", bus.tx_data, 8'h81);
    tick();
    bus.tx_data_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("t5_stall_data", bus.tx_data, 8'h82);
      chk("t5_stall_valid", bus.tx_data_valid, 1);
      chk("t5_stall_ready", bus.req_ready, 0);
      chk("t5_stall_grant", bus.grant, 4'b0100);
    end
    tick();
    bus.tx_data_ready = 1'b1;
    drain("t5_drain", 50);

    // Reset during byte 2 of a req-2 message; req 0 wins afterwards.
    tick();
    push_src(2, 8'hB1, 1'b0, 1'b1);
    push_src(2, 8'hB2, 1'b0, 1'b0);
    push_src(2, 8'hB3, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    push_src(0, 8'h4B, 1'b1, 1'b1);
    push_exp(2, 8'hB2);
    push_exp(2, 8'hB3);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_grant", bus.grant, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_txv", bus.tx_data_valid, 0);
    chk("t6_rst_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("t6_grant0", bus.grant, 4'b0001);
    chk("t6_k1", bus.tx_data, 8'h4B);
    drain("t6_drain", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
